// File: rtl/wts_i2s_transmitter_pkg.sv
// wts_i2s_transmitter_pkg: shared I2S frame constants and sample conversion
package wts_i2s_transmitter_pkg;

    localparam int MIX_W            = 12;
    localparam int SLOT_16          = 16;
    localparam int SLOT_32          = 32;
    localparam int DEFAULT_BCLK_DIV = 4;

    typedef logic [MIX_W-1:0] mix_t;

    // Offset-binary samples become two's complement by flipping the sign bit.
    function automatic mix_t to_signed12(input mix_t s, input bit is_unsigned);
        return {s[MIX_W-1] ^ is_unsigned, s[MIX_W-2:0]};
    endfunction

endpackage

// File: rtl/wts_i2s_transmitter_if.sv
// wts_i2s_transmitter_if: mixer-side sample bus and I2S pins of the transmitter
interface wts_i2s_transmitter_if;
    import wts_i2s_transmitter_pkg::*;

    logic enable;
    logic sample_valid;
    mix_t left_in;
    mix_t right_in;
    logic i2s_bclk;
    logic i2s_lrclk;
    logic i2s_data;
    logic sample_overrun;
    logic sample_underrun;

    modport master (
        output enable, sample_valid, left_in, right_in,
        input  i2s_bclk, i2s_lrclk, i2s_data, sample_overrun, sample_underrun
    );

    modport slave (
        input  enable, sample_valid, left_in, right_in,
        output i2s_bclk, i2s_lrclk, i2s_data, sample_overrun, sample_underrun
    );

endinterface

// File: rtl/wts_i2s_clock_gen.sv
// wts_i2s_clock_gen: bclk divider, fall strobe, bit counter and word select
module wts_i2s_clock_gen
    import wts_i2s_transmitter_pkg::*;
#(
    parameter int BCLK_DIV  = DEFAULT_BCLK_DIV,
    parameter int SLOT_BITS = SLOT_16
) (
    input  logic clk,
    input  logic nreset,
    input  logic enable,
    output logic bclk,
    output logic lrclk,
    output logic fall,
    output logic load
);

    localparam int DW = $clog2(BCLK_DIV + 1);
    localparam int BW = $clog2(2 * SLOT_BITS);

    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic          first;
    logic          tc;

    assign tc   = div_cnt == DW'(BCLK_DIV - 1);
    assign fall = enable && tc && bclk;
    // The first fall after reset or enable always starts a fresh frame.
    assign load = fall && (first || bit_cnt == BW'(2 * SLOT_BITS - 1));

    // Divider and bit counter; lrclk is decoded from the count before it advances so it leads the slot MSB by one bclk.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
            first   <= 1'b1;
        end else if (!enable) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrclk   <= 1'b0;
            first   <= 1'b1;
        end else begin
            div_cnt <= tc ? '0 : div_cnt + 1'b1;
            bclk    <= bclk ^ tc;
            if (fall) begin
                bit_cnt <= load ? '0 : bit_cnt + 1'b1;
                lrclk   <= bit_cnt >= BW'(SLOT_BITS - 1) && bit_cnt <= BW'(2 * SLOT_BITS - 2);
                first   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wts_i2s_transmitter.sv
// wts_i2s_transmitter: captures 12-bit mix samples and serialises them as Philips I2S
module wts_i2s_transmitter
    import wts_i2s_transmitter_pkg::*;
#(
    parameter int BCLK_DIV       = DEFAULT_BCLK_DIV,
    parameter int SLOT_BITS      = SLOT_16,
    parameter bit INPUT_UNSIGNED = 1'b1
) (
    input logic                  clk,
    input logic                  nreset,
    wts_i2s_transmitter_if.slave bus
);

    localparam int FW  = 2 * SLOT_BITS;
    localparam int PAD = SLOT_BITS - MIX_W;

    logic [SLOT_BITS-1:0] hold_l, hold_r;
    logic [FW-1:0]        shift, last, frame;
    logic                 pending, data, overrun, underrun, fall, load;

    wts_i2s_clock_gen #(
        .BCLK_DIV (BCLK_DIV),
        .SLOT_BITS(SLOT_BITS)
    ) u_clock_gen (
        .clk   (clk),
        .nreset(nreset),
        .enable(bus.enable),
        .bclk  (bus.i2s_bclk),
        .lrclk (bus.i2s_lrclk),
        .fall  (fall),
        .load  (load)
    );

    // Without a fresh sample the previous frame is repeated.
    assign frame               = pending ? {hold_l, hold_r} : last;
    assign bus.i2s_data        = data;
    assign bus.sample_overrun  = overrun;
    assign bus.sample_underrun = underrun;

    // Sample capture and pending tracking; a strobe in the load cycle keeps the new sample pending for the next frame.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hold_l   <= '0;
            hold_r   <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (bus.sample_valid) begin
                hold_l <= {to_signed12(bus.left_in, INPUT_UNSIGNED), {PAD{1'b0}}};
                hold_r <= {to_signed12(bus.right_in, INPUT_UNSIGNED), {PAD{1'b0}}};
            end
            pending  <= bus.sample_valid || (pending && !load);
            overrun  <= bus.sample_valid && pending && !load;
            underrun <= load && !pending;
        end
    end

    // Shift register; data is the MSB delayed by one bclk, which gives the I2S one-bit offset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            shift <= '0;
            last  <= '0;
            data  <= 1'b0;
        end else if (!bus.enable) begin
            shift <= '0;
            last  <= '0;
            data  <= 1'b0;
        end else if (fall) begin
            data  <= shift[FW-1];
            shift <= load ? frame : shift << 1;
            if (load) last <= frame;
        end
    end

endmodule

// File: tb/tb_wts_i2s_transmitter.sv
// tb_wts_i2s_transmitter: randomized and directed checks of both input modes against a frame-level model
module tb_wts_i2s_transmitter;

    localparam int DIV = 2;
    localparam int S   = 16;
    localparam logic [31:0] LR_PAT = 32'h0001_FFFE;

    logic        clk = 1'b0, nreset = 1'b0, enable = 1'b0, sv = 1'b0;
    logic [11:0] left = '0, right = '0;
    int          errors = 0, checks = 0;

    wts_i2s_transmitter_if bus_u ();
    wts_i2s_transmitter_if bus_s ();

    assign bus_u.enable = enable;
    assign bus_u.sample_valid = sv;
    assign bus_u.left_in = left;
    assign bus_u.right_in = right;
    assign bus_s.enable = enable;
    assign bus_s.sample_valid = sv;
    assign bus_s.left_in = left;
    assign bus_s.right_in = right;

    wts_i2s_transmitter #(.BCLK_DIV(DIV), .SLOT_BITS(S), .INPUT_UNSIGNED(1'b1)) dut_u (.clk(clk), .nreset(nreset), .bus(bus_u));
    wts_i2s_transmitter #(.BCLK_DIV(DIV), .SLOT_BITS(S), .INPUT_UNSIGNED(1'b0)) dut_s (.clk(clk), .nreset(nreset), .bus(bus_s));

    always #5 clk = ~clk;

    // Reference model: bclk falls every 2*DIV clocks after enable, the first fall loads a frame, then every 2*S falls.
    int          n = 0, exp_ov = 0, exp_un = 0;
    bit          m_pend = 0, m_load;
    logic [11:0] hl = '0, hr = '0;
    logic [31:0] last_u = '0, last_s = '0, fu, fs;
    logic [31:0] exp_u[$], exp_s[$];

    function automatic logic [15:0] cu(input logic [11:0] v);
        int x = int'(v) - 2048;
        return 16'((x & 'hFFF) << 4);
    endfunction

    function automatic logic [15:0] cs(input logic [11:0] v);
        return {v, 4'h0};
    endfunction

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            n = 0; m_pend = 0; last_u = '0; last_s = '0;
        end else begin
            m_load = enable && ((n + 1) % (2 * DIV) == 0) && (((n + 1) / (2 * DIV)) % (2 * S) == 1);
            if (m_load) begin
                fu = m_pend ? {cu(hl), cu(hr)} : last_u;
                fs = m_pend ? {cs(hl), cs(hr)} : last_s;
                exp_u.push_back(fu); exp_s.push_back(fs);
                last_u = fu; last_s = fs;
                if (!m_pend) exp_un++;
            end
            if (sv) begin
                if (m_pend && !m_load) exp_ov++;
                hl = left; hr = right; m_pend = 1;
            end else if (m_load) m_pend = 0;
            if (enable) n++;
            else begin n = 0; last_u = '0; last_s = '0; end
        end
    end

    // Observation: {lrclk,data} at each bclk rise, plus pulse counters, sampled on the falling clk edge.
    logic [1:0]  bits_u[$], bits_s[$];
    logic        pb_u = 1'b0, pb_s = 1'b0;
    int          ov_u = 0, un_u = 0, ov_s = 0, un_s = 0;
    logic [31:0] got_u[8], got_s[8], lr_u[8], lr_s[8];

    always @(negedge clk) begin
        if (bus_u.i2s_bclk && !pb_u) bits_u.push_back({bus_u.i2s_lrclk, bus_u.i2s_data});
        if (bus_s.i2s_bclk && !pb_s) bits_s.push_back({bus_s.i2s_lrclk, bus_s.i2s_data});
        pb_u = bus_u.i2s_bclk; pb_s = bus_s.i2s_bclk;
        if (bus_u.sample_overrun) ov_u++;
        if (bus_u.sample_underrun) un_u++;
        if (bus_s.sample_overrun) ov_s++;
        if (bus_s.sample_underrun) un_s++;
    end

    function automatic logic [9:0] outs();
        return {bus_u.i2s_bclk, bus_u.i2s_lrclk, bus_u.i2s_data, bus_u.sample_overrun, bus_u.sample_underrun,
                bus_s.i2s_bclk, bus_s.i2s_lrclk, bus_s.i2s_data, bus_s.sample_overrun, bus_s.sample_underrun};
    endfunction

    task automatic clear_q();
        bits_u.delete(); bits_s.delete(); exp_u.delete(); exp_s.delete();
    endtask

    task automatic stop();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        clear_q();
    endtask

    task automatic strobe(input logic [11:0] a, input logic [11:0] b);
        left = a; right = b; sv = 1'b1;
        @(negedge clk);
        sv = 1'b0;
    endtask

    task automatic strobe_at(input int t, input logic [11:0] a, input logic [11:0] b);
        for (int k = 0; k < 5000 && n != t; k++) @(negedge clk);
        strobe(a, b);
    endtask

    // Waits for nf whole frames (rise 0 precedes the load, rise 1 is stale) and unpacks words and lrclk patterns.
    task automatic collect(input int nf);
        int t = 0;
        while ((bits_u.size() < 2 + 32 * nf || bits_s.size() < 2 + 32 * nf) && t < 3000) begin
            @(negedge clk); t++;
        end
        checks++;
        if (t >= 3000) begin errors++; $display("FAIL collect_timeout: got %0d bits want %0d", bits_u.size(), 2 + 32 * nf); end
        for (int f = 0; f < nf; f++)
            for (int j = 1; j <= 32; j++) begin
                got_u[f][32-j] = bits_u[1+32*f+j][0]; lr_u[f][32-j] = bits_u[1+32*f+j][1];
                got_s[f][32-j] = bits_s[1+32*f+j][0]; lr_s[f][32-j] = bits_s[1+32*f+j][1];
            end
    endtask

    task automatic test_reset();
        nreset = 1'b0; enable = 1'b0; sv = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== 10'd0) begin errors++; $display("FAIL reset_outs: got %b want 0", outs()); end
        nreset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 20 == 19) begin
                checks++;
                if (outs() !== 10'd0) begin errors++; $display("FAIL idle_outs: got %b want 0", outs()); end
            end
        end
    endtask

    task automatic test_basic();
        int u0 = un_u;
        strobe(12'hFFF, 12'h800);
        enable = 1'b1;
        collect(3);
        for (int f = 0; f < 3; f++) begin
            checks += 4;
            if (got_u[f] !== exp_u[f]) begin errors++; $display("FAIL basic_u_frame%0d: got %h want %h", f, got_u[f], exp_u[f]); end
            if (got_s[f] !== exp_s[f]) begin errors++; $display("FAIL basic_s_frame%0d: got %h want %h", f, got_s[f], exp_s[f]); end
            if (lr_u[f] !== LR_PAT) begin errors++; $display("FAIL basic_u_lr%0d: got %h want %h", f, lr_u[f], LR_PAT); end
            if (lr_s[f] !== LR_PAT) begin errors++; $display("FAIL basic_s_lr%0d: got %h want %h", f, lr_s[f], LR_PAT); end
        end
        checks += 3;
        if (got_u[0] !== 32'h7FF0_0000) begin errors++; $display("FAIL basic_const: got %h want 7ff00000", got_u[0]); end
        if (got_u[2] !== 32'h7FF0_0000) begin errors++; $display("FAIL underrun_repeat: got %h want 7ff00000", got_u[2]); end
        if (un_u - u0 !== 3) begin errors++; $display("FAIL underrun_pulses: got %0d want 3", un_u - u0); end
        stop();
    endtask

    task automatic test_signed();
        strobe(12'h800, 12'h001);
        enable = 1'b1;
        collect(1);
        checks += 3;
        if (got_s[0] !== 32'h8000_0010) begin errors++; $display("FAIL signed_const: got %h want 80000010", got_s[0]); end
        if (got_s[0] !== exp_s[0]) begin errors++; $display("FAIL signed_s_frame: got %h want %h", got_s[0], exp_s[0]); end
        if (got_u[0] !== exp_u[0]) begin errors++; $display("FAIL signed_u_frame: got %h want %h", got_u[0], exp_u[0]); end
        stop();
    endtask

    task automatic test_overrun();
        int o0 = ov_u;
        enable = 1'b1;
        strobe_at(10, 12'h123, 12'h321);
        strobe_at(50, 12'h456, 12'h654);
        strobe_at(200, 12'h0AB, 12'h0CD);
        strobe_at(259, 12'h789, 12'hABC);
        collect(4);
        for (int f = 0; f < 4; f++) begin
            checks += 2;
            if (got_u[f] !== exp_u[f]) begin errors++; $display("FAIL overrun_u_frame%0d: got %h want %h", f, got_u[f], exp_u[f]); end
            if (got_s[f] !== exp_s[f]) begin errors++; $display("FAIL overrun_s_frame%0d: got %h want %h", f, got_s[f], exp_s[f]); end
        end
        checks += 4;
        if (got_u[1] !== 32'hC560_E540) begin errors++; $display("FAIL overrun_newest: got %h want c560e540", got_u[1]); end
        if (got_s[2] !== 32'h0AB0_0CD0) begin errors++; $display("FAIL loadcycle_old: got %h want 0ab00cd0", got_s[2]); end
        if (got_s[3] !== 32'h7890_ABC0) begin errors++; $display("FAIL loadcycle_new: got %h want 7890abc0", got_s[3]); end
        if (ov_u - o0 !== 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", ov_u - o0); end
        stop();
    endtask

    task automatic test_enable_drop();
        strobe(12'($urandom), 12'($urandom));
        enable = 1'b1;
        for (int k = 0; k < 3000 && bits_u.size() < 22; k++) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (outs() !== 10'd0) begin errors++; $display("FAIL drop_outs: got %b want 0", outs()); end
        clear_q();
        strobe(12'($urandom), 12'($urandom));
        enable = 1'b1;
        collect(1);
        checks += 8;
        if (got_u[0] !== exp_u[0]) begin errors++; $display("FAIL drop_u_frame: got %h want %h", got_u[0], exp_u[0]); end
        if (got_s[0] !== exp_s[0]) begin errors++; $display("FAIL drop_s_frame: got %h want %h", got_s[0], exp_s[0]); end
        if (lr_u[0] !== LR_PAT) begin errors++; $display("FAIL drop_u_lr: got %h want %h", lr_u[0], LR_PAT); end
        if (lr_s[0] !== LR_PAT) begin errors++; $display("FAIL drop_s_lr: got %h want %h", lr_s[0], LR_PAT); end
        if (ov_u !== exp_ov) begin errors++; $display("FAIL drop_ov_u: got %0d want %0d", ov_u, exp_ov); end
        if (un_u !== exp_un) begin errors++; $display("FAIL drop_un_u: got %0d want %0d", un_u, exp_un); end
        if (ov_s !== exp_ov) begin errors++; $display("FAIL drop_ov_s: got %0d want %0d", ov_s, exp_ov); end
        if (un_s !== exp_un) begin errors++; $display("FAIL drop_un_s: got %0d want %0d", un_s, exp_un); end
        stop();
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            enable = 1'b1;
            for (int i = 0; i < 6; i++) begin
                repeat ($urandom_range(40, 200)) @(negedge clk);
                strobe(12'($urandom), 12'($urandom));
            end
            collect(5);
            for (int f = 0; f < 5; f++) begin
                checks += 2;
                if (got_u[f] !== exp_u[f]) begin errors++; $display("FAIL random%0d_u_frame%0d: got %h want %h", r, f, got_u[f], exp_u[f]); end
                if (got_s[f] !== exp_s[f]) begin errors++; $display("FAIL random%0d_s_frame%0d: got %h want %h", r, f, got_s[f], exp_s[f]); end
            end
            stop();
            checks += 2;
            if (ov_u !== exp_ov) begin errors++; $display("FAIL random%0d_ov: got %0d want %0d", r, ov_u, exp_ov); end
            if (un_s !== exp_un) begin errors++; $display("FAIL random%0d_un: got %0d want %0d", r, un_s, exp_un); end
        end
    endtask

    task automatic test_reset_mid();
        strobe(12'h5A5, 12'hA5A);
        enable = 1'b1;
        for (int k = 0; k < 5000 && n != 60; k++) @(negedge clk);
        nreset = 1'b0;
        #1;
        checks++;
        if (outs() !== 10'd0) begin errors++; $display("FAIL reset_mid_outs: got %b want 0", outs()); end
        @(negedge clk);
        clear_q();
        nreset = 1'b1;
        collect(1);
        checks += 3;
        if (got_u[0] !== 32'h0) begin errors++; $display("FAIL reset_mid_zero: got %h want 0", got_u[0]); end
        if (got_s[0] !== exp_s[0]) begin errors++; $display("FAIL reset_mid_s_frame: got %h want %h", got_s[0], exp_s[0]); end
        if (lr_u[0] !== LR_PAT) begin errors++; $display("FAIL reset_mid_lr: got %h want %h", lr_u[0], LR_PAT); end
        stop();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_overrun();
        test_enable_drop();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wts_i2s_transmitter.md
Name: wts_i2s_transmitter

Overview:
Output stage placed directly after the wave table sound channel mixer. Captures each 12-bit left/right mix sample from a sample strobe into a holding register and converts it to two's complement. Serialises each pair as a standard Philips I2S frame on a bit clock divided from the system clock, so the wave table sound core can drive an external audio DAC or codec.

Parameters:
BCLK_DIV, 4, clk cycles per bclk half-period (>=1)
SLOT_BITS, 16, bits per channel slot (16 or 32; 12 data bits MSB-justified, rest zero)
INPUT_UNSIGNED, 1, 1: input is offset-binary (+2048 centred), MSB is inverted on capture; 0: input already two's complement

Ports:
clk  input  1  system clock
nreset  input  1  asynchronous active-low reset
enable  input  1  1: serialiser runs; 0: serialiser idle, outputs low
sample_valid  input  1  one-clk strobe, left_in/right_in valid
left_in  input  12  left mix sample
right_in  input  12  right mix sample
i2s_bclk  output  1  bit clock
i2s_lrclk  output  1  word select, 0 = left
i2s_data  output  1  serial data, MSB first
sample_overrun  output  1  one-clk pulse, pending sample overwritten before use
sample_underrun  output  1  one-clk pulse, frame started with no new sample

Behaviour:
- Reset, asynchronous: all outputs 0, divider/bit counter 0, hold/shift registers 0, pending=0.
- Capture: on sample_valid, hold_l/hold_r <= conv(in). conv: 12-bit value, MSB inverted when INPUT_UNSIGNED=1, then zero-extended on the right to SLOT_BITS. Example: 12'hFFF becomes 16'h7FF0. Sets pending.
- Overrun: if sample_valid while pending=1 and no frame load happens in the same cycle, the hold registers are overwritten and sample_overrun pulses.
- Divider: div_cnt counts 0..BCLK_DIV-1 while enable=1; at the terminal count, i2s_bclk toggles.
  - "fall" = the cycle in which i2s_bclk goes 1->0.
  - Every output change (lrclk, data, counters) happens only on fall, in the same clk edge as the bclk toggle.
- Bit counter: bit_cnt 0..2*SLOT_BITS-1 advances on each fall and wraps to 0.
- Frame load (bit_cnt 2S-1 -> 0, where S=SLOT_BITS):
  - If pending: shift <= {hold_l, hold_r}, pending cleared.
  - Else: shift reloads the previous frame's words and sample_underrun pulses.
  - If sample_valid arrives in the load cycle: the old hold is loaded, the new sample is captured and pending stays 1. No overrun.
- Word select: i2s_lrclk = 1 for bit_cnt S-1..2S-2, else 0, so it changes one bclk before each slot MSB.
- Data: i2s_data is the shift-register MSB delayed by one bclk (I2S one-bit delay).
  - Left MSB is driven at bit_cnt=1 (the fall after lrclk drops).
  - Right LSB is driven at bit_cnt=0 of the next frame.
- First frame after reset or after enable rises: no sample pending gives a zero frame and one underrun pulse.
- enable=0 (any time, including mid-frame):
  - Next clk: div_cnt=0, bit_cnt=0, bclk=0, lrclk=0, data=0, shift cleared.
  - Capture and pending logic keep running.
  - On re-enable, the first fall performs a frame load.
- Reset mid-frame aborts immediately; no partial frame resumes.
- Bclk frequency = clk/(2*BCLK_DIV). The sample rate must be <= bclk/(2*S) or overruns result. The integrator dump rate of the mixer fixes the strobe cadence.

Decomposition:
- Shared package: I2S frame constants (slot widths), offset-to-signed conversion function, default divider value.
- One natural sub-module, wts_i2s_clock_gen: divider, bclk, fall strobe, bit_cnt, lrclk.
- Capture/pending logic and shift register stay in the top.

Test Plan:
- Reset/idle: nreset=0 then 1, enable=0 for 100 clk -> bclk, lrclk, data, overrun and underrun all 0.
- Basic frame, BCLK_DIV=2, S=16, INPUT_UNSIGNED=1: left_in=12'hFFF, right_in=12'h800 strobed once before the first load -> bits on the bclk rising edge: left slot 16'h7FF0, right slot 16'h0000; lrclk toggles one bclk before each MSB; bclk period 4 clk; no underrun in that frame.
- Signed mode, INPUT_UNSIGNED=0: left_in=12'h800, right_in=12'h001 -> left 16'h8000, right 16'h0010.
- Underrun: no strobe for two frames after the first -> each frame repeats the previous words; sample_underrun pulses once per frame load.
- Overrun and simultaneity:
  - Two strobes within one frame (12'h123, then 12'h456) -> one overrun pulse; the next frame carries 12'h456's conversion.
  - Strobe in the exact load cycle -> no overrun; the old sample is sent and the new one is sent in the following frame.
- Enable drop mid-right-slot: enable=0 at bit_cnt=20, then 1 -> outputs 0 the next clk; after re-enable, the first fall loads a full frame with lrclk=0.
